// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and types for the multi-port register file
package rf_pkg;
    localparam int               XLEN_DEF    = 32;
    localparam int               NREGS_DEF   = 32;
    localparam int               AW_DEF      = 5;
    localparam int               PRE_IDX_DEF = 8;
    localparam logic [31:0]      PRE_VAL_DEF = 32'h48;

    typedef logic [AW_DEF-1:0]   rf_addr_t;
    typedef logic [XLEN_DEF-1:0] rf_data_t;
endpackage

// File: rtl/rf_wr_arb.sv
// rtl/rf_wr_arb.sv - per-entry write strobe/data select, port 1 over port 0, zero-register drop
module rf_wr_arb
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = AW_DEF,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     wa,
    input  logic [NWR*XLEN-1:0]   wd,
    output logic [NREGS-1:0]      wstb,
    output logic [NREGS*XLEN-1:0] wdat
);

    // Ascending port loop: the highest-numbered enabled port is assigned last and wins.
    always_comb begin
        wstb = '0;
        wdat = '0;
        for (int e = 0; e < NREGS; e++) begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] == AW'(e)) && !(ZERO_REG != 0 && e == 0)) begin
                    wstb[e]                = 1'b1;
                    wdat[e*XLEN +: XLEN]   = wd[j*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with async reads and preset on reset
// Define RF_BYPASS_EN for write-first forwarding of same-cycle writes onto the read ports.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              NREGS    = NREGS_DEF,
    parameter int              AW       = AW_DEF,
    parameter int              NRD      = 2,
    parameter int              NWR      = 2,
    parameter int              ZERO_REG = 1,
    parameter int              PRE_IDX  = PRE_IDX_DEF,
    parameter logic [XLEN-1:0] PRE_VAL  = XLEN'(PRE_VAL_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*XLEN-1:0]  rd,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*XLEN-1:0]  wd
);

    logic [XLEN-1:0]       mem_q [NREGS];
    logic [XLEN-1:0]       mem_d [NREGS];
    logic [NREGS-1:0]      wstb;
    logic [NREGS*XLEN-1:0] wdat;
    logic [AW-1:0]         rd_addr;
    logic [XLEN-1:0]       rd_val;

    rf_wr_arb #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .AW       (AW),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_wr_arb (
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .wstb (wstb),
        .wdat (wdat)
    );

    always_comb begin
        for (int e = 0; e < NREGS; e++) begin
            mem_d[e] = wstb[e] ? wdat[e*XLEN +: XLEN] : mem_q[e];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NREGS; e++) begin
                mem_q[e] <= (e == PRE_IDX) ? PRE_VAL : '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Zero-register masking is applied last so it also hides a preset landing on entry 0.
    always_comb begin
        rd      = '0;
        rd_addr = '0;
        rd_val  = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_addr = ra[i*AW +: AW];
            rd_val  = mem_q[rd_addr];
`ifdef RF_BYPASS_EN
            if (wstb[rd_addr]) begin
                rd_val = wdat[rd_addr*XLEN +: XLEN];
            end
`endif
            if (ZERO_REG != 0 && rd_addr == '0) begin
                rd_val = '0;
            end
            rd[i*XLEN +: XLEN] = rd_val;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed and random checks of reg_file_mp (ZERO_REG=1 and ZERO_REG=0)
module tb_reg_file_mp;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ra;
    logic [63:0] rd_z1;
    logic [63:0] rd_z0;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;

    int n_checks = 0;
    int n_fails  = 0;

    rf_data_t m_z1 [32];
    rf_data_t m_z0 [32];

    always #5 clk = ~clk;

    reg_file_mp #(.ZERO_REG(1)) dut (
        .clk (clk), .rst (rst), .ra (ra), .rd (rd_z1), .we (we), .wa (wa), .wd (wd)
    );

    reg_file_mp #(.ZERO_REG(0)) dut_z0 (
        .clk (clk), .rst (rst), .ra (ra), .rd (rd_z0), .we (we), .wa (wa), .wd (wd)
    );

    function automatic rf_data_t exp_read(input bit zr, input rf_addr_t a);
        rf_data_t v;
        if (zr && a == 0) return '0;
        v = zr ? m_z1[a] : m_z0[a];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < 2; j++) begin
            if (we[j] && wa[j*5 +: 5] == a) v = wd[j*32 +: 32];
        end
`endif
        return v;
    endfunction

    task automatic commit();
        @(posedge clk);
        for (int k = 0; k < 32; k++) begin
            if (rst) begin
                m_z1[k] = (k == 8) ? 32'h48 : 32'h0;
                m_z0[k] = (k == 8) ? 32'h48 : 32'h0;
            end
        end
        if (!rst) begin
            for (int j = 0; j < 2; j++) begin
                if (we[j]) begin
                    if (wa[j*5 +: 5] != 0) m_z1[wa[j*5 +: 5]] = wd[j*32 +: 32];
                    m_z0[wa[j*5 +: 5]] = wd[j*32 +: 32];
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] w, input rf_addr_t wa0, input rf_data_t wd0,
                         input rf_addr_t wa1, input rf_data_t wd1, input rf_addr_t ra0, input rf_addr_t ra1);
        @(negedge clk);
        rst = r;
        we  = w;
        wa  = {wa1, wa0};
        wd  = {wd1, wd0};
        ra  = {ra1, ra0};
        #1;
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            assert (rd_z1[i*32 +: 32] === exp_read(1'b1, ra[i*5 +: 5])) else begin
                n_fails++;
                $error("FAIL %s z1 port%0d ra=%0d: observed %h expected %h", tag, i, ra[i*5 +: 5],
                       rd_z1[i*32 +: 32], exp_read(1'b1, ra[i*5 +: 5]));
            end
            n_checks++;
            assert (rd_z0[i*32 +: 32] === exp_read(1'b0, ra[i*5 +: 5])) else begin
                n_fails++;
                $error("FAIL %s z0 port%0d ra=%0d: observed %h expected %h", tag, i, ra[i*5 +: 5],
                       rd_z0[i*32 +: 32], exp_read(1'b0, ra[i*5 +: 5]));
            end
        end
    endtask

    task automatic check_val(input string tag, input rf_data_t obs, input rf_data_t expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        rst = 1'b1; we = '0; wa = '0; wd = '0; ra = '0;

        // reset, then preset/zero readback
        drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8, 5'd0);
        commit();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8, 5'd0);
        check_val("reset_preset_r8", rd_z1[31:0], 32'h48);
        check_val("reset_r0", rd_z1[63:32], 32'h0);
        check_model("reset_a");
        commit();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 5'd31);
        check_val("reset_r1", rd_z1[31:0], 32'h0);
        check_val("reset_r31", rd_z1[63:32], 32'h0);
        commit();

        // dual write to distinct addresses
        drive(1'b0, 2'b11, 5'd3, 32'hAAAA0001, 5'd4, 32'h55550002, 5'd3, 5'd4);
        check_model("dual_pre");
        commit();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4);
        check_val("dual_r3", rd_z1[31:0], 32'hAAAA0001);
        check_val("dual_r4", rd_z1[63:32], 32'h55550002);
        commit();

        // same-address conflict: port 1 wins
        drive(1'b0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd7, 5'd3);
        check_model("conflict_pre");
        commit();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7);
        check_val("conflict_r7", rd_z1[31:0], 32'h22);
        check_val("conflict_r7_z0", rd_z0[63:32], 32'h22);
        commit();

        // zero-register write
        drive(1'b0, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd0, 5'd0);
        check_model("zero_pre");
        commit();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        check_val("zero_r0_zr1", rd_z1[31:0], 32'h0);
        check_val("zero_r0_zr0", rd_z0[31:0], 32'hFFFFFFFF);
        commit();

        // conflict on entry 0 with ZERO_REG=0 keeps port-1 priority
        drive(1'b0, 2'b11, 5'd0, 32'h1234, 5'd0, 32'h5678, 5'd0, 5'd8);
        commit();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        check_val("zero_conflict_zr0", rd_z0[31:0], 32'h5678);
        check_val("zero_conflict_zr1", rd_z1[31:0], 32'h0);
        commit();

        // reset overrides a same-edge write
        drive(1'b1, 2'b01, 5'd8, 32'h99, 5'd0, 32'h0, 5'd8, 5'd3);
        commit();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8, 5'd3);
        check_val("rst_vs_wr_r8", rd_z1[31:0], 32'h48);
        check_val("rst_clears_r3", rd_z1[63:32], 32'h0);
        commit();

        // first post-reset edge writes normally, then forwarding behaviour
        drive(1'b0, 2'b01, 5'd5, 32'h10, 5'd0, 32'h0, 5'd1, 5'd1);
        commit();
        drive(1'b0, 2'b10, 5'd0, 32'h0, 5'd5, 32'h20, 5'd5, 5'd1);
`ifdef RF_BYPASS_EN
        check_val("bypass_pre_edge", rd_z1[31:0], 32'h20);
`else
        check_val("bypass_pre_edge", rd_z1[31:0], 32'h10);
`endif
        check_model("bypass_pre");
        commit();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd1);
        check_val("bypass_post_edge", rd_z1[31:0], 32'h20);
        commit();

        // random traffic with rare resets and narrow address range to provoke conflicts
        for (int t = 0; t < 400; t++) begin
            drive(($urandom_range(0, 31) == 0), 2'($urandom),
                  5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 9)), 5'($urandom));
            check_model("random");
            commit();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
